// File: rtl/ir_tx_modulator.sv
// On-off-keyed IR transmit modulator: serialises bytes LSB-first, one carrier burst per 1-bit,
// and drives the registered LED gate and sink-current enable code.
module ir_tx_modulator #(
  parameter int CNT_W  = 16,
  parameter int BLEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [BLEN_W-1:0] cfg_bit_len,
  input  logic [7:0]        cfg_cbit,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ir_pwm,
  output logic [7:0]        cbit_ir,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high;
  logic [BLEN_W-1:0] r_bit_len;
  logic [7:0]        r_cbit;
  logic [7:0]        r_shift;

  logic [CNT_W-1:0]  r_phase;
  logic [BLEN_W-1:0] r_per;
  logic [2:0]        r_bit;

  logic              r_ir_pwm;
  logic [7:0]        r_cbit_ir;

  logic [CNT_W-1:0]  w_p_last;
  logic [BLEN_W-1:0] w_n_last;
  logic              w_phase_wrap;
  logic              w_per_wrap;
  logic              w_final;
  logic              w_accept;
  logic              w_tx_ready;
  logic              w_pwm_nxt;
  logic [7:0]        w_cbit_nxt;

  // Terminal counts with the period clamped to >=2 and the bit length to >=1
  assign w_p_last     = (r_period < CNT_W'(2)) ? CNT_W'(1) : r_period - CNT_W'(1);
  assign w_n_last     = (r_bit_len == '0) ? '0 : r_bit_len - BLEN_W'(1);
  assign w_phase_wrap = (r_phase == w_p_last);
  assign w_per_wrap   = w_phase_wrap && (r_per == w_n_last);
  assign w_final      = w_per_wrap && (r_bit == 3'd7);
  assign w_accept     = tx_valid && w_tx_ready;

  assign tx_ready = w_tx_ready;
  assign ir_pwm   = r_ir_pwm;
  assign cbit_ir  = r_cbit_ir;
  assign busy     = (r_state == S_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_ready  = 1'b0;
    w_pwm_nxt   = 1'b0;
    w_cbit_nxt  = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_tx_ready = 1'b1;
        if (tx_valid) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        // Accepting on the final cycle keeps SEND for a gapless next byte
        w_tx_ready = w_final;
        w_pwm_nxt  = r_shift[0] && (r_phase < r_high);
        w_cbit_nxt = r_cbit;
        if (w_final && !tx_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= '0;
      r_high    <= '0;
      r_bit_len <= '0;
      r_cbit    <= '0;
      r_shift   <= '0;
      r_phase   <= '0;
      r_per     <= '0;
      r_bit     <= '0;
    end else if (w_accept) begin
      r_period  <= cfg_period;
      r_high    <= cfg_high;
      r_bit_len <= cfg_bit_len;
      r_cbit    <= cfg_cbit;
      r_shift   <= tx_data;
      r_phase   <= '0;
      r_per     <= '0;
      r_bit     <= '0;
    end else if (r_state == S_SEND) begin
      if (w_phase_wrap) begin
        r_phase <= '0;
        if (w_per_wrap) begin
          r_per   <= '0;
          r_bit   <= r_bit + 3'd1;
          r_shift <= {1'b0, r_shift[7:1]};
        end else begin
          r_per <= r_per + BLEN_W'(1);
        end
      end else begin
        r_phase <= r_phase + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_pwm  <= 1'b0;
      r_cbit_ir <= 8'h00;
    end else begin
      r_ir_pwm  <= w_pwm_nxt;
      r_cbit_ir <= w_cbit_nxt;
    end
  end

endmodule

// File: tb/tb_ir_tx_modulator.sv
// Self-checking bench for ir_tx_modulator: directed and randomized bytes compared cycle by cycle
// against a per-cycle waveform model derived from the byte/config arithmetic.
module tb_ir_tx_modulator;
  localparam int CNT_W  = 16;
  localparam int BLEN_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_high = '0;
  logic [BLEN_W-1:0] cfg_bit_len = '0;
  logic [7:0]        cfg_cbit = '0;
  logic [7:0]        tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic              ir_pwm;
  logic [7:0]        cbit_ir;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] b_data [2];
  int         b_p    [2];
  int         b_h    [2];
  int         b_n    [2];
  logic [7:0] b_cbit [2];

  ir_tx_modulator #(.CNT_W(CNT_W), .BLEN_W(BLEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_bit_len(cfg_bit_len), .cfg_cbit(cfg_cbit),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ir_pwm(ir_pwm), .cbit_ir(cbit_ir), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int byte_len(input int p, input int n);
    int pe, ne;
    pe = (p < 2) ? 2 : p;
    ne = (n < 1) ? 1 : n;
    return 8 * pe * ne;
  endfunction

  // Gate value for cycle i of a byte: bit index from whole bit-times, phase within the carrier period
  function automatic logic model_pwm(input logic [7:0] d, input int p, input int h, input int n, input int i);
    int pe, ne;
    pe = (p < 2) ? 2 : p;
    ne = (n < 1) ? 1 : n;
    return d[i / (ne * pe)] && ((i % pe) < h);
  endfunction

  task automatic set_b(input int idx, input logic [7:0] d, input int p, input int h, input int n,
                       input logic [7:0] c);
    b_data[idx] = d;
    b_p[idx]    = p;
    b_h[idx]    = h;
    b_n[idx]    = n;
    b_cbit[idx] = c;
  endtask

  task automatic apply(input int idx);
    tx_data     = b_data[idx];
    cfg_period  = 16'(b_p[idx]);
    cfg_high    = 16'(b_h[idx]);
    cfg_bit_len = 8'(b_n[idx]);
    cfg_cbit    = b_cbit[idx];
    tx_valid    = 1'b1;
  endtask

  task automatic scramble();
    tx_data     = 8'($urandom);
    cfg_period  = 16'($urandom);
    cfg_high    = 16'($urandom);
    cfg_bit_len = 8'($urandom);
    cfg_cbit    = 8'($urandom);
  endtask

  task automatic run(input int nb, input string name);
    int len0, total, bi, off;
    len0  = byte_len(b_p[0], b_n[0]);
    total = len0 + ((nb == 2) ? byte_len(b_p[1], b_n[1]) : 0);
    check({name, "_ready_idle"}, tx_ready, 1);
    apply(0);
    @(posedge clk); #1;
    check({name, "_busy_acc"}, busy, 1);
    if (nb == 2) apply(1);
    else begin
      tx_valid = 1'b0;
      scramble();
    end
    for (int i = 0; i < total; i++) begin
      @(posedge clk); #1;
      bi  = (i < len0) ? 0 : 1;
      off = i - bi * len0;
      check($sformatf("%s_pwm[%0d]", name, i), ir_pwm,
            model_pwm(b_data[bi], b_p[bi], b_h[bi], b_n[bi], off));
      check($sformatf("%s_cbit[%0d]", name, i), cbit_ir, b_cbit[bi]);
      check($sformatf("%s_busy[%0d]", name, i), busy, (i < total - 1));
      check($sformatf("%s_ready[%0d]", name, i), tx_ready, (i == len0 - 2) || (i >= total - 2));
      if (nb == 2 && i == len0 - 1) begin
        tx_valid = 1'b0;
        scramble();
      end
    end
    @(posedge clk); #1;
    check({name, "_pwm_end"}, ir_pwm, 0);
    check({name, "_cbit_end"}, cbit_ir, 0);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_ready_end"}, tx_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_pwm", ir_pwm, 0);
    check("rst_cbit", cbit_ir, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_b(0, 8'hA5, 4, 2, 2, 8'h0F); run(1, "basic");
    set_b(0, 8'hFF, 3, 1, 1, 8'h3C);
    set_b(1, 8'h00, 3, 1, 1, 8'h3C); run(2, "b2b");
    set_b(0, 8'hA5, 0, 1, 1, 8'h55); run(1, "p0");
    set_b(0, 8'h96, 3, 1, 0, 8'hAA); run(1, "n0");
    set_b(0, 8'h01, 4, 5, 1, 8'hF0); run(1, "hbig");
    set_b(0, 8'hFF, 4, 0, 2, 8'h81); run(1, "h0");

    // Reset asserted in the middle of a byte
    set_b(0, 8'hFF, 4, 4, 2, 8'h77);
    apply(0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_pwm", ir_pwm, 1);
    check("mid_cbit", cbit_ir, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", ir_pwm, 0);
    check("arst_cbit", cbit_ir, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", tx_ready, 1);
    @(posedge clk); #1;
    check("arst_hold_busy", busy, 0);
    check("arst_hold_pwm", ir_pwm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_b(0, 8'h5A, 2, 1, 1, 8'h11); run(1, "post_rst");

    for (int t = 0; t < 20; t++) begin
      int nb;
      nb = int'($urandom_range(1, 2));
      for (int k = 0; k < nb; k++)
        set_b(k, 8'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 8'($urandom));
      run(nb, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
